// File: rtl/seq_detect_prog.sv
// Runtime-programmable Mealy sequence detector.
// The pattern, its length and the overlap mode are written through a small
// configuration port while the detector is idle (CFG). While enabled (RUN),
// valid input symbols are compared against the stored pattern. The match
// output is combinational, so it asserts in the same cycle as the final
// symbol. A saturating counter records the number of matches.
module seq_detect_prog #(
   parameter int SYM_W   = 1,
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 16,
   localparam int IDX_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
   localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             cfg_sym_we,
   input  logic [IDX_W-1:0] cfg_idx,
   input  logic [SYM_W-1:0] cfg_sym,
   input  logic             cfg_len_we,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             cfg_ovl,
   output logic             cfg_err,
   input  logic             din_valid,
   input  logic [SYM_W-1:0] din,
   output logic             match,
   output logic [CNT_W-1:0] match_cnt,
   input  logic             cnt_clr
);

   // The history holds at most MAX_LEN-1 symbols; keep one dummy entry
   // when the pattern can only be a single symbol long.
   localparam int HIST_N = (MAX_LEN > 1) ? MAX_LEN - 1 : 1;

   typedef enum logic {
      ST_CFG = 1'b0,
      ST_RUN = 1'b1
   } state_t;

   state_t           state_reg;

   // Programmed pattern: pat_reg[0] is the first symbol of the sequence.
   logic [SYM_W-1:0] pat_reg [MAX_LEN];
   logic [LEN_W-1:0] len_reg;
   logic             ovl_reg;

   // Accepted-symbol history: hist_reg[0] is the most recent symbol.
   logic [SYM_W-1:0] hist_reg [HIST_N];
   logic [LEN_W-1:0] depth_reg;

   logic             run_active;
   logic             leave_run;
   logic             accept;
   logic             flush_hist;
   logic             cfg_open;
   logic             sym_idx_ok;
   logic             len_ok;
   logic             sym_wr;
   logic             len_wr;
   logic             err_next;
   logic [LEN_W-1:0] last_idx;
   logic [LEN_W-1:0] depth_sat;
   logic [IDX_W-1:0] tail_idx;
   logic [HIST_N-1:0] hist_ok;
   logic             depth_ok;
   logic             tail_ok;
   logic             match_int;

   // ------------------------------------------------------------------
   // Run control. Symbols are only consumed while in RUN with enable
   // still high; the cycle that drops enable is the RUN->CFG transition
   // and consumes nothing.
   // ------------------------------------------------------------------
   assign run_active = (state_reg == ST_RUN) && enable;
   assign leave_run  = (state_reg == ST_RUN) && !enable;
   assign accept     = run_active && din_valid;

   // ------------------------------------------------------------------
   // Match evaluation. With L = len_reg, the incoming symbol must equal
   // pat[L-1] and hist[k] must equal pat[L-2-k] for every k < L-1.
   // Index arithmetic is done modulo 2**IDX_W; the true index always
   // fits, so the wrap never matters for entries that are compared.
   // ------------------------------------------------------------------
   assign last_idx = len_reg - LEN_W'(1);
   assign tail_idx = IDX_W'(len_reg) - IDX_W'(1);
   assign depth_ok = (depth_reg >= last_idx);
   assign tail_ok  = (din == pat_reg[tail_idx]);

   genvar gi;
   generate
      for (gi = 0; gi < HIST_N; gi++) begin : g_hist_cmp
         logic [IDX_W-1:0] pat_idx;
         assign pat_idx = IDX_W'(len_reg) - IDX_W'(gi + 2);
         // Entries beyond the active pattern length are don't-care.
         assign hist_ok[gi] = ((gi + 2) > int'(len_reg)) ||
                              (hist_reg[gi] == pat_reg[pat_idx]);
      end
   endgenerate

   assign match_int = !rst && accept && depth_ok && (&hist_ok) && tail_ok;
   assign match     = match_int;

   // Depth grows with each accepted symbol but never past len-1, which
   // is all the history a match can ever need.
   assign depth_sat = (depth_reg < last_idx) ? (depth_reg + LEN_W'(1)) : last_idx;

   // Leaving RUN discards the partial sequence; so does a completed
   // match in non-overlapping mode, so its last symbol is not reused.
   assign flush_hist = leave_run || (accept && match_int && !ovl_reg);

   // ------------------------------------------------------------------
   // Configuration write qualification. Writes only land while idle in
   // CFG; anything else, or an out-of-range value, is refused and
   // reported one cycle later on cfg_err.
   // ------------------------------------------------------------------
   assign cfg_open   = (state_reg == ST_CFG) && !enable;
   assign sym_idx_ok = (int'(cfg_idx) < MAX_LEN);
   assign len_ok     = (cfg_len != '0) && (int'(cfg_len) <= MAX_LEN);
   assign sym_wr     = cfg_sym_we && cfg_open && sym_idx_ok;
   assign len_wr     = cfg_len_we && cfg_open && len_ok;
   assign err_next   = (cfg_sym_we && !(cfg_open && sym_idx_ok)) ||
                       (cfg_len_we && !(cfg_open && len_ok));

   // CFG/RUN state machine with the registered configuration-error pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_CFG;
         cfg_err   <= 1'b0;
      end else begin
         cfg_err <= err_next;
         case (state_reg)
            ST_CFG: begin
               if (enable) begin
                  state_reg <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (!enable) begin
                  state_reg <= ST_CFG;
               end
            end
         endcase
      end
   end

   // Pattern storage, written one symbol at a time.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < MAX_LEN; k++) begin
            pat_reg[k] <= '0;
         end
      end else if (sym_wr) begin
         pat_reg[cfg_idx] <= cfg_sym;
      end
   end

   // Pattern length and overlap mode, written together.
   always_ff @(posedge clk) begin
      if (rst) begin
         len_reg <= LEN_W'(MAX_LEN);
         ovl_reg <= 1'b1;
      end else if (len_wr) begin
         len_reg <= cfg_len;
         ovl_reg <= cfg_ovl;
      end
   end

   // Symbol history shift register and its valid depth.
   always_ff @(posedge clk) begin
      if (rst || flush_hist) begin
         for (int k = 0; k < HIST_N; k++) begin
            hist_reg[k] <= '0;
         end
         depth_reg <= '0;
      end else if (accept) begin
         hist_reg[0] <= din;
         for (int k = 1; k < HIST_N; k++) begin
            hist_reg[k] <= hist_reg[k-1];
         end
         depth_reg <= depth_sat;
      end
   end

   // Saturating match counter; a clear coinciding with a match counts it.
   always_ff @(posedge clk) begin
      if (rst) begin
         match_cnt <= '0;
      end else if (cnt_clr) begin
         match_cnt <= CNT_W'(match_int);
      end else if (match_int && (match_cnt != '1)) begin
         match_cnt <= match_cnt + CNT_W'(1);
      end
   end

endmodule
